prog_loader: RTL and testbench

- Writer side of the instruction-memory load interface.
- Assembles 32-bit instruction words from a byte stream delivered by the UART receiver, then writes them to consecutive instruction-memory addresses starting at 0.
- Drives the memory's loading flag, address and instruction inputs.
- Ends the load when it writes a HALT word (opcode 6'b111111), or flags an error on memory overflow or an inter-byte timeout.
- Sits between the UART RX and the instruction memory, under the debug unit's control.

---
 rtl/prog_loader_pkg.sv | 17 +
 rtl/prog_loader_word_assembler.sv | 75 +++++++
 rtl/prog_loader.sv | 125 ++++++++++++
 tb/tb_prog_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared constants for the instruction-memory loader: word geometry,
// the HALT opcode (also decoded by the instruction memory) and FSM encodings.
package prog_loader_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_BYTE_WIDTH = 8;
    localparam int unsigned BYTES_PER_WORD = DEF_DATA_WIDTH / DEF_BYTE_WIDTH;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RECEIVE = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_ERROR   = 3'd4;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs an MSB-first byte stream into words and watches the gap between
// bytes of a partially received word.
module word_assembler
    import prog_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned BYTE_WIDTH     = DEF_BYTE_WIDTH,
    parameter int unsigned BYTES          = BYTES_PER_WORD,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  capture_i,
    input  logic                  tmo_en_i,
    input  logic                  rx_done_i,
    input  logic [BYTE_WIDTH-1:0] rx_data_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic                  word_valid_o,
    output logic                  timeout_o
);

    localparam int unsigned CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        word_valid_o = 1'b0;
        timeout_o    = 1'b0;
        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
            tmo_d   = '0;
        end else if (capture_i && rx_done_i) begin
            shift_d = {shift_q[DATA_WIDTH-BYTE_WIDTH-1:0], rx_data_i};
            tmo_d   = '0;
            if (cnt_q == CW'(BYTES - 1)) begin
                cnt_d        = '0;
                word_valid_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (tmo_en_i && (cnt_q != '0)) begin
            // The gap is only timed once a word has started arriving.
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout_o = 1'b1;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    // The completed word is offered in the same cycle as its last byte.
    assign word_o = shift_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads UART-received instruction words into consecutive instruction-memory
// addresses until a HALT word, memory overflow or an inter-byte timeout.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned BYTE_WIDTH     = DEF_BYTE_WIDTH,
    parameter int unsigned MEM_DEPTH      = 32,
    parameter int unsigned SIZEOP         = 6,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic [BYTE_WIDTH-1:0]        i_rx_data,
    input  logic                         i_rx_done,
    output logic                         o_loading,
    output logic                         o_wr_en,
    output logic [DATA_WIDTH-1:0]        o_address,
    output logic [DATA_WIDTH-1:0]        o_instruccion,
    output logic [$clog2(MEM_DEPTH):0]   o_word_count,
    output logic                         o_done,
    output logic                         o_error
);

    localparam int unsigned BPW = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned WCW = $clog2(MEM_DEPTH) + 1;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [WCW-1:0]        wcount_q, wcount_d;
    logic                  asm_clear, asm_valid, asm_timeout;
    logic [DATA_WIDTH-1:0] asm_word;
    logic                  in_receive, in_write, is_halt;

    assign in_receive = (state_q == ST_RECEIVE);
    assign in_write   = (state_q == ST_WRITE);
    assign is_halt    = (instr_q[DATA_WIDTH-1 -: SIZEOP] == SIZEOP'(HALT_OPCODE));

    // Capture stays on during WRITE so a byte landing there starts the next word.
    word_assembler #(
        .DATA_WIDTH    (DATA_WIDTH),
        .BYTE_WIDTH    (BYTE_WIDTH),
        .BYTES         (BPW),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_word_assembler (
        .clk_i       (i_clock),
        .rst_ni      (i_reset),
        .clear_i     (asm_clear),
        .capture_i   (in_receive | in_write),
        .tmo_en_i    (in_receive),
        .rx_done_i   (i_rx_done),
        .rx_data_i   (i_rx_data),
        .word_o      (asm_word),
        .word_valid_o(asm_valid),
        .timeout_o   (asm_timeout)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_addr_d = wr_addr_q;
        instr_d   = instr_q;
        wcount_d  = wcount_q;
        asm_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_d   = ST_RECEIVE;
                    addr_d    = '0;
                    wcount_d  = '0;
                    asm_clear = 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (asm_timeout) begin
                    state_d = ST_ERROR;
                end else if (asm_valid) begin
                    state_d   = ST_WRITE;
                    instr_d   = asm_word;
                    wr_addr_d = addr_q;
                end
            end
            ST_WRITE: begin
                wcount_d = wcount_q + 1'b1;
                if (is_halt) begin
                    state_d = ST_DONE;
                end else if (addr_q == DATA_WIDTH'(MEM_DEPTH - 1)) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_RECEIVE;
                    addr_d  = addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wr_addr_q <= '0;
            instr_q   <= '0;
            wcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_addr_q <= wr_addr_d;
            instr_q   <= instr_d;
            wcount_q  <= wcount_d;
        end
    end

    assign o_loading     = in_receive | in_write;
    assign o_wr_en       = in_write;
    assign o_address     = wr_addr_q;
    assign o_instruccion = instr_q;
    assign o_word_count  = wcount_q;
    assign o_done        = (state_q == ST_DONE);
    assign o_error       = (state_q == ST_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Randomised self-checking bench for prog_loader against a word-level load model.
module tb_prog_loader;

    localparam int TMO   = 50;
    localparam int DEPTH = 32;

    logic        i_clock, i_reset, i_start, i_rx_done;
    logic [7:0]  i_rx_data;
    logic        o_loading, o_wr_en, o_done, o_error;
    logic [31:0] o_address, o_instruccion;
    logic [5:0]  o_word_count;

    prog_loader #(
        .DATA_WIDTH    (32),
        .BYTE_WIDTH    (8),
        .MEM_DEPTH     (DEPTH),
        .SIZEOP        (6),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_rx_data    (i_rx_data),
        .i_rx_done    (i_rx_done),
        .o_loading    (o_loading),
        .o_wr_en      (o_wr_en),
        .o_address    (o_address),
        .o_instruccion(o_instruccion),
        .o_word_count (o_word_count),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] wq[$];
    logic [63:0] eq[$];
    logic [7:0]  bq[$];
    bit          exp_done, exp_err;
    int          exp_cnt;

    always @(negedge i_clock)
        if (o_wr_en === 1'b1) wq.push_back({o_address, o_instruccion});

    // Expected writes and outcome, derived from the byte stream alone.
    task automatic model_load();
        logic [31:0] w;
        int addr;
        eq.delete();
        addr = 0; exp_cnt = 0; exp_done = 0; exp_err = 0;
        for (int i = 0; i + 3 < bq.size(); i += 4) begin
            w = {bq[i], bq[i+1], bq[i+2], bq[i+3]};
            eq.push_back({32'(addr), w});
            exp_cnt++;
            if (w[31:26] == 6'h3F) begin exp_done = 1; break; end
            if (addr == DEPTH - 1) begin exp_err = 1; break; end
            addr++;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) bq.push_back(w[k*8 +: 8]);
    endtask

    function automatic logic [31:0] rand_plain();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    task automatic pulse_start();
        wq.delete();
        @(negedge i_clock); i_start = 1'b1;
        @(negedge i_clock); i_start = 1'b0;
    endtask

    task automatic send_bytes(input int max_gap);
        int g;
        for (int i = 0; i < bq.size(); i++) begin
            @(negedge i_clock); i_rx_data = bq[i]; i_rx_done = 1'b1;
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                @(negedge i_clock); i_rx_done = 1'b0; i_rx_data = 8'($urandom);
            end
        end
        @(negedge i_clock); i_rx_done = 1'b0;
    endtask

    task automatic wait_end(output bit expired);
        int n = 0;
        while (!(o_done === 1'b1 || o_error === 1'b1) && n < 2000) begin
            @(negedge i_clock); n++;
        end
        expired = (n >= 2000);
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        repeat (6) begin
            @(negedge i_clock);
            i_start = 1'($urandom); i_rx_done = 1'($urandom); i_rx_data = 8'($urandom);
        end
        checks++; if (o_loading !== 1'b0) begin failures++; $display("FAIL reset_loading got=%b want=0", o_loading); end
        checks++; if (o_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b want=0", o_wr_en); end
        checks++; if (o_address !== 32'd0) begin failures++; $display("FAIL reset_address got=%h want=0", o_address); end
        checks++; if (o_instruccion !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h want=0", o_instruccion); end
        checks++; if (o_word_count !== 6'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", o_word_count); end
        checks++; if (o_done !== 1'b0 || o_error !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", o_done, o_error); end
        wq.delete();
        i_start = 1'b0;
        @(negedge i_clock); i_reset = 1'b1;
        repeat (12) begin
            @(negedge i_clock); i_rx_done = 1'($urandom); i_rx_data = 8'($urandom);
        end
        i_rx_done = 1'b0;
        checks++; if ({o_loading, o_done, o_error} !== 3'b000 || wq.size() != 0) begin
            failures++; $display("FAIL idle_no_start got=%b%b%b writes=%0d want=000 writes=0", o_loading, o_done, o_error, wq.size());
        end
    endtask

    task automatic test_two_word();
        bit expired;
        bq = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFC, 8'h00, 8'h00, 8'h00};
        pulse_start();
        send_bytes(3);
        wait_end(expired);
        checks++; if (expired) begin failures++; $display("FAIL two_word_wait got=timeout want=done"); end
        checks++; if (wq.size() != 2) begin failures++; $display("FAIL two_word_nwrites got=%0d want=2", wq.size()); end
        checks++; if (wq.size() > 0 && wq[0] !== {32'd0, 32'h20010005}) begin failures++; $display("FAIL two_word_w0 got=%h want=%h", wq[0], {32'd0, 32'h20010005}); end
        checks++; if (wq.size() > 1 && wq[1] !== {32'd1, 32'hFC000000}) begin failures++; $display("FAIL two_word_w1 got=%h want=%h", wq[1], {32'd1, 32'hFC000000}); end
        checks++; if ({o_done, o_error, o_loading} !== 3'b100) begin failures++; $display("FAIL two_word_flags got=%b%b%b want=100", o_done, o_error, o_loading); end
        checks++; if (o_word_count !== 6'd2) begin failures++; $display("FAIL two_word_count got=%0d want=2", o_word_count); end
    endtask

    task automatic test_random_loads();
        bit expired;
        int nw;
        for (int r = 0; r < 5; r++) begin
            bq.delete();
            nw = $urandom_range(6, 1);
            for (int w = 0; w < nw - 1; w++) push_word(rand_plain());
            push_word({6'h3F, 26'($urandom)});
            model_load();
            pulse_start();
            if (r == 0) begin
                // Waiting for byte 1 of a word must never time out.
                repeat (3 * TMO) @(negedge i_clock);
                checks++; if (o_error !== 1'b0 || o_loading !== 1'b1) begin failures++; $display("FAIL idle_first_byte got err=%b load=%b want err=0 load=1", o_error, o_loading); end
            end
            send_bytes(4);
            wait_end(expired);
            checks++; if (expired) begin failures++; $display("FAIL rand%0d_wait got=timeout want=done", r); end
            checks++; if ({o_done, o_error, o_loading} !== {exp_done, exp_err, 1'b0}) begin failures++; $display("FAIL rand%0d_flags got=%b%b%b want=%b%b0", r, o_done, o_error, o_loading, exp_done, exp_err); end
            checks++; if (o_word_count !== 6'(exp_cnt)) begin failures++; $display("FAIL rand%0d_count got=%0d want=%0d", r, o_word_count, exp_cnt); end
            checks++; if (wq.size() != eq.size()) begin failures++; $display("FAIL rand%0d_nwrites got=%0d want=%0d", r, wq.size(), eq.size()); end
            for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
                checks++; if (wq[i] !== eq[i]) begin failures++; $display("FAIL rand%0d_write%0d got=%h want=%h", r, i, wq[i], eq[i]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit expired;
        bq.delete();
        push_word(rand_plain());
        push_word(rand_plain());
        push_word({6'h3F, 26'($urandom)});
        model_load();
        pulse_start();
        send_bytes(0);
        wait_end(expired);
        checks++; if (expired) begin failures++; $display("FAIL b2b_wait got=timeout want=done"); end
        checks++; if (o_done !== 1'b1 || o_word_count !== 6'd3) begin failures++; $display("FAIL b2b_done got done=%b count=%0d want done=1 count=3", o_done, o_word_count); end
        checks++; if (wq.size() != 3) begin failures++; $display("FAIL b2b_nwrites got=%0d want=3", wq.size()); end
        for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
            checks++; if (wq[i] !== eq[i]) begin failures++; $display("FAIL b2b_write%0d got=%h want=%h", i, wq[i], eq[i]); end
        end
    endtask

    task automatic test_timeout();
        bit expired;
        logic [31:0] hw;
        bq = '{8'($urandom), 8'($urandom)};
        pulse_start();
        send_bytes(0);
        repeat (TMO - 5) @(negedge i_clock);
        checks++; if (o_error !== 1'b0) begin failures++; $display("FAIL timeout_early got=%b want=0", o_error); end
        wait_end(expired);
        checks++; if (expired || o_error !== 1'b1) begin failures++; $display("FAIL timeout_error got=%b want=1", o_error); end
        checks++; if (o_loading !== 1'b0 || o_done !== 1'b0 || wq.size() != 0) begin failures++; $display("FAIL timeout_state got load=%b done=%b writes=%0d want 0 0 0", o_loading, o_done, wq.size()); end
        hw = {6'h3F, 26'($urandom)};
        bq.delete();
        push_word(hw);
        pulse_start();
        send_bytes(3);
        wait_end(expired);
        checks++; if (expired || {o_done, o_error} !== 2'b10 || o_word_count !== 6'd1) begin failures++; $display("FAIL timeout_restart got done=%b err=%b count=%0d want 1 0 1", o_done, o_error, o_word_count); end
        checks++; if (wq.size() != 1 || wq[0] !== {32'd0, hw}) begin failures++; $display("FAIL timeout_restart_write got n=%0d want n=1 data=%h", wq.size(), {32'd0, hw}); end
    endtask

    task automatic test_overflow();
        bit expired;
        bq.delete();
        for (int w = 0; w < DEPTH + 1; w++) push_word(rand_plain());
        model_load();
        pulse_start();
        send_bytes(2);
        wait_end(expired);
        repeat (5) @(negedge i_clock);
        checks++; if (expired || o_error !== 1'b1 || o_done !== 1'b0) begin failures++; $display("FAIL overflow_flags got err=%b done=%b want 1 0", o_error, o_done); end
        checks++; if (o_word_count !== 6'(DEPTH)) begin failures++; $display("FAIL overflow_count got=%0d want=%0d", o_word_count, DEPTH); end
        checks++; if (wq.size() != DEPTH) begin failures++; $display("FAIL overflow_nwrites got=%0d want=%0d", wq.size(), DEPTH); end
        for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
            checks++; if (wq[i] !== eq[i]) begin failures++; $display("FAIL overflow_write%0d got=%h want=%h", i, wq[i], eq[i]); end
        end
    endtask

    task automatic test_mid_reset();
        bit expired;
        bq.delete();
        push_word(rand_plain());
        bq.push_back(8'($urandom));
        bq.push_back(8'($urandom));
        pulse_start();
        send_bytes(1);
        checks++; if (o_loading !== 1'b1) begin failures++; $display("FAIL midreset_pre got=%b want=1", o_loading); end
        @(posedge i_clock); #2 i_reset = 1'b0;
        #1;
        checks++; if (o_loading !== 1'b0 || o_wr_en !== 1'b0) begin failures++; $display("FAIL midreset_async got load=%b wr=%b want 0 0", o_loading, o_wr_en); end
        @(negedge i_clock); i_reset = 1'b1;
        bq.delete();
        push_word(rand_plain());
        push_word({6'h3F, 26'($urandom)});
        model_load();
        pulse_start();
        send_bytes(2);
        wait_end(expired);
        checks++; if (expired || o_done !== 1'b1 || o_word_count !== 6'd2) begin failures++; $display("FAIL midreset_restart got done=%b count=%0d want 1 2", o_done, o_word_count); end
        checks++; if (wq.size() != 2) begin failures++; $display("FAIL midreset_nwrites got=%0d want=2", wq.size()); end
        for (int i = 0; i < wq.size() && i < eq.size(); i++) begin
            checks++; if (wq[i] !== eq[i]) begin failures++; $display("FAIL midreset_write%0d got=%h want=%h", i, wq[i], eq[i]); end
        end
    endtask

    initial begin
        i_reset = 1'b0; i_start = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
        test_reset();
        test_two_word();
        test_random_loads();
        test_back_to_back();
        test_timeout();
        test_overflow();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
